// File: rtl/adc_pkg.sv
// Shared types for the ramp ADC capture stage.
// Holds the capture FSM encoding and the ramp full-scale helper.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    TRACK,
    HOLD
  } cap_state_t;

  function automatic int ramp_max(int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/comparator_sync.sv
// Multi-flop synchronizer for the asynchronous comparator output.
// Cleared by a synchronous active-low reset.
module comparator_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/ramp_adc_capture.sv
// Ramp-compare ADC: latches the ramp code where the comparator trips,
// averages 2**AVG_LOG2 conversions and emits one sample per group.
module ramp_adc_capture
  import adc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] ramp_in,
  input  logic             comp_in,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             overrange
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(ramp_max(WIDTH));
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CW-1:0] NCONV = CW'(2 ** AVG_LOG2);

  logic             comp_s;
  logic [WIDTH-1:0] ramp_q;
  logic [SW-1:0]    settle_q, settle_d;
  cap_state_t       state_q, state_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_acc_q, ovr_acc_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             wrap;
  logic             change;
  logic             trip;
  logic             done;
  logic             done_ovr;
  logic [WIDTH-1:0] done_code;

  comparator_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .async_i(comp_in),
    .sync_o (comp_s)
  );

  assign wrap   = (ramp_q == MAX) && (ramp_in == '0);
  assign change = (ramp_in != ramp_q);
  assign trip   = (settle_q == '0) && comp_s;

  always_comb begin
    settle_d  = settle_q;
    state_d   = state_q;
    cap_d     = cap_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovr_acc_d = ovr_acc_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    ovr_d     = ovr_q;
    done      = 1'b0;
    done_ovr  = 1'b0;
    done_code = cap_q;

    if (change) begin
      settle_d = SW'(SETTLE_CYCLES);
    end else if (settle_q != '0) begin
      settle_d = settle_q - SW'(1);
    end

    // A full group is published one clock after its last conversion.
    if (cnt_q == NCONV) begin
      sample_d  = acc_q[AVG_LOG2 +: WIDTH];
      ovr_d     = ovr_acc_q;
      valid_d   = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
      ovr_acc_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ALIGN;
      end
      ALIGN: begin
        if (wrap) state_d = TRACK;
      end
      TRACK: begin
        if (wrap) begin
          done      = 1'b1;
          done_code = MAX;
          done_ovr  = 1'b1;
        end else if (trip) begin
          cap_d   = ramp_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (wrap) begin
          done    = 1'b1;
          state_d = TRACK;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      acc_d     = acc_d + AW'(done_code);
      cnt_d     = cnt_d + CW'(1);
      ovr_acc_d = ovr_acc_d | done_ovr;
    end

    if (!enable) begin
      state_d   = IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      ovr_acc_d = 1'b0;
      sample_d  = sample_q;
      ovr_d     = ovr_q;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ramp_q    <= '0;
      settle_q  <= '0;
      state_q   <= IDLE;
      cap_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovr_acc_q <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ramp_q    <= ramp_in;
      settle_q  <= settle_d;
      state_q   <= state_d;
      cap_q     <= cap_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovr_acc_q <= ovr_acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrange    = ovr_q;

endmodule

// File: tb/tb_ramp_adc_capture.sv
// Randomized bench for ramp_adc_capture: two instances (no averaging
// and 4x averaging) share one ramp and comparator model.
module tb_ramp_adc_capture;

  localparam int H = 7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] ramp_in;
  logic       comp_in;
  logic [7:0] s0, s2;
  logic       v0, v2, o0, o2;

  always #5 clk = ~clk;

  ramp_adc_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .SETTLE_CYCLES(4), .AVG_LOG2(0)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ramp_in(ramp_in), .comp_in(comp_in),
    .sample_out(s0), .sample_valid(v0), .overrange(o0)
  );

  ramp_adc_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .SETTLE_CYCLES(4), .AVG_LOG2(2)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ramp_in(ramp_in), .comp_in(comp_in),
    .sample_out(s2), .sample_valid(v2), .overrange(o2)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wrap_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: one conversion per aligned ramp period.
  // Encoded expectation = overrange*256 + sample.
  int  acc[2];
  int  cnt[2];
  bit  ovr[2];
  int  last_e[2];
  bit  aligned;
  int  q0[$];
  int  q2[$];

  task automatic model_conv(int code, bit ov);
    for (int k = 0; k < 2; k++) begin
      int l;
      int e;
      l = (k == 0) ? 0 : 2;
      acc[k] += code;
      cnt[k]++;
      ovr[k] = ovr[k] | ov;
      if (cnt[k] == (1 << l)) begin
        e = (ovr[k] ? 256 : 0) + (acc[k] >> l);
        if (k == 0) q0.push_back(e);
        else q2.push_back(e);
        last_e[k] = e;
        acc[k] = 0;
        cnt[k] = 0;
        ovr[k] = 1'b0;
      end
    end
  endtask

  task automatic model_abort(bit is_reset);
    for (int k = 0; k < 2; k++) begin
      acc[k] = 0;
      cnt[k] = 0;
      ovr[k] = 1'b0;
      if (is_reset) last_e[k] = 0;
    end
    aligned = 1'b0;
  endtask

  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      chk("lat0", cyc - wrap_cyc, 2);
      if (q0.size() == 0) chk("extra0", 1, 0);
      else chk("smp0", {o0, s0}, q0.pop_front());
    end
    if (v2 === 1'b1) begin
      chk("lat2", cyc - wrap_cyc, 2);
      if (q2.size() == 0) chk("extra2", 1, 0);
      else chk("smp2", {o2, s2}, q2.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ramp(int thr, int thr_next, int g, int goff, int ab);
    for (int c = 1; c < 256; c++) begin
      for (int o = 0; o < H; o++) begin
        step();
        ramp_in = 8'(c);
        comp_in = (c >= thr) || (c == g && o == goff);
        if (ab != 0 && c == 128 && o == 0) begin
          if (ab == 1) reset_n = 1'b0;
          else enable = 1'b0;
        end
        if (ab != 0 && c == 128 && o == 1) begin
          reset_n = 1'b1;
          enable  = 1'b1;
          if (ab == 1) begin
            chk("rst_s0", {v0, o0, s0}, 0);
            chk("rst_s2", {v2, o2, s2}, 0);
          end else begin
            chk("hold0", {v0, o0, s0}, last_e[0]);
            chk("hold2", {v2, o2, s2}, last_e[1]);
          end
          model_abort(ab == 1);
        end
      end
    end
    step();
    ramp_in  = 8'd0;
    comp_in  = (thr_next <= 0);
    wrap_cyc = cyc;
    if (aligned) model_conv((thr > 255) ? 255 : thr, thr > 255);
    else aligned = 1'b1;
    for (int o = 1; o < H; o++) step();
  endtask

  int thr_l[$];
  int g_l[$];
  int ab_l[$];

  task automatic add(int thr, int g, int ab);
    thr_l.push_back(thr);
    g_l.push_back(g);
    ab_l.push_back(ab);
  endtask

  task automatic add_rand(int ab);
    int thr;
    int g;
    thr = $urandom_range(0, 256);
    g = -1;
    if (thr > 1 && $urandom_range(0, 1) == 1)
      g = $urandom_range(1, (thr - 1 > 254) ? 254 : thr - 1);
    add(thr, g, ab);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    ramp_in = 8'd0;
    comp_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      acc[k] = 0;
      cnt[k] = 0;
      ovr[k] = 1'b0;
      last_e[k] = 0;
    end
    aligned = 1'b0;

    add(50, -1, 0);
    add(100, -1, 0);
    add(256, -1, 0);
    add(0, -1, 0);
    add(100, -1, 0);
    add(100, -1, 0);
    add(101, -1, 0);
    add(102, -1, 0);
    add(103, -1, 0);
    add(120, 40, 0);
    for (int i = 0; i < 6; i++) add_rand(0);
    add_rand(1);
    for (int i = 0; i < 4; i++) add_rand(0);
    add_rand(2);
    for (int i = 0; i < 4; i++) add_rand(0);

    repeat (3) step();
    chk("reset0", {v0, o0, s0}, 0);
    chk("reset2", {v2, o2, s2}, 0);
    reset_n = 1'b1;
    comp_in = (thr_l[0] <= 0);
    step();
    enable = 1'b1;

    for (int i = 0; i < thr_l.size(); i++) begin
      run_ramp(thr_l[i],
               (i + 1 < thr_l.size()) ? thr_l[i + 1] : 256,
               g_l[i], $urandom_range(0, 2), ab_l[i]);
    end

    // Ramp stalls at 0: no further samples may appear.
    repeat (60) step();
    chk("pend0", q0.size(), 0);
    chk("pend2", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
